// File: rtl/axi_wr_responder.sv
// AXI3 write-only responder backed by a 64-bit word store.
// Accepts one AW burst at a time, absorbs its W beats, answers with one B.
// A side read port gives registered access to the store for inspection.
//
// state | meaning
// IDLE  | waiting for an AW handshake (awready=1)
// DATA  | absorbing W beats until beat awlen+1 (wready=1)
// RESP  | presenting B until bready (bvalid=1)
module axi_wr_responder #(
   parameter int          DATA_WIDTH = 64,
   parameter int          MEM_DEPTH  = 1024,
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
   input  logic                         aclk,
   input  logic                         rst_i,
   input  logic [31:0]                  s_axi_awaddr,
   input  logic                         s_axi_awvalid,
   output logic                         s_axi_awready,
   input  logic [3:0]                   s_axi_awlen,
   input  logic [2:0]                   s_axi_awsize,
   input  logic [1:0]                   s_axi_awburst,
   input  logic [DATA_WIDTH-1:0]        s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]      s_axi_wstrb,
   input  logic                         s_axi_wlast,
   input  logic                         s_axi_wvalid,
   output logic                         s_axi_wready,
   output logic                         s_axi_bvalid,
   input  logic                         s_axi_bready,
   output logic [1:0]                   s_axi_bresp,
   input  logic [$clog2(MEM_DEPTH)-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0]        rd_data_o,
   output logic [31:0]                  beat_count_o,
   output logic [31:0]                  burst_count_o,
   output logic                         proto_err_o
);

   localparam int IW     = $clog2(MEM_DEPTH);
   localparam int STRB_W = DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

   state_t          state_q, state_d;
   logic [31:0]     addr_q, addr_d;
   logic [3:0]      len_q, len_d;
   logic [2:0]      size_q, size_d;
   logic [1:0]      burst_q, burst_d;
   logic [3:0]      beat_q, beat_d;
   logic            err_q, err_d;
   logic            proto_q, proto_d;
   logic [31:0]     beat_cnt_q, beat_cnt_d;
   logic [31:0]     burst_cnt_q, burst_cnt_d;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   logic            w_hs;
   logic            burst_ok;
   logic            in_range;
   logic            last_beat;
   logic            wr_en;
   logic [31:0]     offset;
   logic [IW-1:0]   word_idx;

   // Address decode for the current beat; wrap-around of the subtraction
   // below BASE_ADDR is caught by the explicit compare.
   always_comb begin
      offset   = addr_q - BASE_ADDR;
      in_range = (addr_q >= BASE_ADDR) && ((offset >> 3) < 32'(MEM_DEPTH));
      word_idx = offset[IW+2:3];
      burst_ok = (size_q == 3'd3) && ((burst_q == 2'b00) || (burst_q == 2'b01));
   end

   // Next-state logic, handshake outputs and burst bookkeeping.
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      len_d         = len_q;
      size_d        = size_q;
      burst_d       = burst_q;
      beat_d        = beat_q;
      err_d         = err_q;
      proto_d       = proto_q;
      beat_cnt_d    = beat_cnt_q;
      burst_cnt_d   = burst_cnt_q;
      s_axi_awready = (state_q == IDLE);
      s_axi_wready  = (state_q == DATA);
      s_axi_bvalid  = (state_q == RESP);
      s_axi_bresp   = ((state_q == RESP) && err_q) ? 2'b10 : 2'b00;
      w_hs          = (state_q == DATA) && s_axi_wvalid;
      last_beat     = (beat_q == len_q);

      unique case (state_q)
         IDLE: begin
            if (s_axi_awvalid) begin
               addr_d  = s_axi_awaddr;
               len_d   = s_axi_awlen;
               size_d  = s_axi_awsize;
               burst_d = s_axi_awburst;
               beat_d  = 4'd0;
               err_d   = 1'b0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (w_hs) begin
               beat_cnt_d = beat_cnt_q + 32'd1;
               beat_d     = beat_q + 4'd1;
               if (!burst_ok || !in_range)
                  err_d = 1'b1;
               if (s_axi_wlast != last_beat) begin
                  err_d   = 1'b1;
                  proto_d = 1'b1;
               end
               if (burst_q == 2'b01)
                  addr_d = addr_q + 32'd8;
               if (last_beat)
                  state_d = RESP;
            end
         end
         RESP: begin
            if (s_axi_bready) begin
               burst_cnt_d = burst_cnt_q + 32'd1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign wr_en = w_hs && burst_ok && in_range && !rst_i;

   // Control registers; reset abandons any burst in flight.
   always_ff @(posedge aclk) begin
      if (rst_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         size_q      <= '0;
         burst_q     <= '0;
         beat_q      <= '0;
         err_q       <= 1'b0;
         proto_q     <= 1'b0;
         beat_cnt_q  <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         size_q      <= size_d;
         burst_q     <= burst_d;
         beat_q      <= beat_d;
         err_q       <= err_d;
         proto_q     <= proto_d;
         beat_cnt_q  <= beat_cnt_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   // Word store with byte enables and a registered read port; a read of the
   // word being written returns the old contents. Not touched by reset.
   always_ff @(posedge aclk) begin
      if (wr_en) begin
         for (int k = 0; k < STRB_W; k++) begin
            if (s_axi_wstrb[k])
               mem[word_idx][8*k +: 8] <= s_axi_wdata[8*k +: 8];
         end
      end
      rd_data_q <= mem[rd_addr_i];
   end

   assign rd_data_o     = rd_data_q;
   assign beat_count_o  = beat_cnt_q;
   assign burst_count_o = burst_cnt_q;
   assign proto_err_o   = proto_q;

endmodule

// File: tb/tb_axi_wr_responder.sv
// Directed bench for axi_wr_responder: inputs change on the falling edge,
// outputs are sampled on the falling edge, handshakes occur on the rising edge.
module tb_axi_wr_responder;

   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        aclk = 1'b0;
   logic        rst_i;
   logic [31:0] s_axi_awaddr;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [3:0]  s_axi_awlen;
   logic [2:0]  s_axi_awsize;
   logic [1:0]  s_axi_awburst;
   logic [63:0] s_axi_wdata;
   logic [7:0]  s_axi_wstrb;
   logic        s_axi_wlast;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic        s_axi_bvalid;
   logic        s_axi_bready;
   logic [1:0]  s_axi_bresp;
   logic [9:0]  rd_addr_i;
   logic [63:0] rd_data_o;
   logic [31:0] beat_count_o;
   logic [31:0] burst_count_o;
   logic        proto_err_o;

   int          checks   = 0;
   int          failures = 0;
   int          exp_beats  = 0;
   int          exp_bursts = 0;
   logic [1:0]  resp;
   logic [63:0] rdv;
   logic        saw_bvalid;

   axi_wr_responder dut (
      .aclk          (aclk),
      .rst_i         (rst_i),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_awlen   (s_axi_awlen),
      .s_axi_awsize  (s_axi_awsize),
      .s_axi_awburst (s_axi_awburst),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wlast   (s_axi_wlast),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_bresp   (s_axi_bresp),
      .rd_addr_i     (rd_addr_i),
      .rd_data_o     (rd_data_o),
      .beat_count_o  (beat_count_o),
      .burst_count_o (burst_count_o),
      .proto_err_o   (proto_err_o)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic do_aw(input logic [31:0] a, input logic [3:0] len,
                        input logic [2:0] sz, input logic [1:0] bt);
      int n = 0;
      s_axi_awaddr  = a;
      s_axi_awlen   = len;
      s_axi_awsize  = sz;
      s_axi_awburst = bt;
      s_axi_awvalid = 1'b1;
      while (!s_axi_awready && n < 20) begin
         @(posedge aclk); @(negedge aclk); n++;
      end
      chk("aw_ready", {63'd0, s_axi_awready}, 64'd1);
      @(posedge aclk); @(negedge aclk);
      s_axi_awvalid = 1'b0;
   endtask

   task automatic do_w(input logic [63:0] d, input logic [7:0] st, input logic last);
      int n = 0;
      s_axi_wdata  = d;
      s_axi_wstrb  = st;
      s_axi_wlast  = last;
      s_axi_wvalid = 1'b1;
      while (!s_axi_wready && n < 20) begin
         @(posedge aclk); @(negedge aclk); n++;
      end
      if (!s_axi_wready) chk("w_ready_timeout", {63'd0, s_axi_wready}, 64'd1);
      else exp_beats++;
      @(posedge aclk); @(negedge aclk);
      s_axi_wvalid = 1'b0;
      s_axi_wlast  = 1'b0;
   endtask

   task automatic do_b(output logic [1:0] r);
      int n = 0;
      s_axi_bready = 1'b1;
      while (!s_axi_bvalid && n < 20) begin
         @(posedge aclk); @(negedge aclk); n++;
      end
      chk("b_valid", {63'd0, s_axi_bvalid}, 64'd1);
      if (s_axi_bvalid) exp_bursts++;
      r = s_axi_bresp;
      @(posedge aclk); @(negedge aclk);
      s_axi_bready = 1'b0;
   endtask

   task automatic rd(input int idx, output logic [63:0] v);
      rd_addr_i = 10'(idx);
      @(posedge aclk); @(negedge aclk);
      v = rd_data_o;
   endtask

   initial begin
      rst_i = 1'b1;
      s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_awlen = '0;
      s_axi_awsize = '0; s_axi_awburst = '0; s_axi_wdata = '0;
      s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
      s_axi_bready = 1'b0; rd_addr_i = '0;
      repeat (3) @(negedge aclk);
      rst_i = 1'b0;

      // reset state
      chk("rst_awready", {63'd0, s_axi_awready}, 64'd1);
      chk("rst_wready",  {63'd0, s_axi_wready},  64'd0);
      chk("rst_bvalid",  {63'd0, s_axi_bvalid},  64'd0);
      chk("rst_bresp",   {62'd0, s_axi_bresp},   64'd0);
      chk("rst_beats",   {32'd0, beat_count_o},  64'd0);
      chk("rst_bursts",  {32'd0, burst_count_o}, 64'd0);
      chk("rst_proto",   {63'd0, proto_err_o},   64'd0);

      // wvalid in IDLE is ignored
      s_axi_wvalid = 1'b1;
      chk("idle_wready", {63'd0, s_axi_wready}, 64'd0);
      @(posedge aclk); @(negedge aclk);
      s_axi_wvalid = 1'b0;
      chk("idle_beats", {32'd0, beat_count_o}, 64'd0);

      // 16-beat INCR from BASE, data = beat index
      do_aw(BASE, 4'd15, 3'd3, 2'b01);
      chk("data_awready", {63'd0, s_axi_awready}, 64'd0);
      for (int i = 0; i < 16; i++) do_w(64'(i), 8'hFF, i == 15);
      do_b(resp);
      chk("incr16_bresp",  {62'd0, resp}, 64'd0);
      chk("incr16_beats",  {32'd0, beat_count_o},  64'(exp_beats));
      chk("incr16_bursts", {32'd0, burst_count_o}, 64'(exp_bursts));
      chk("incr16_proto",  {63'd0, proto_err_o}, 64'd0);
      for (int i = 0; i < 16; i++) begin
         rd(i, rdv);
         chk($sformatf("incr16_mem%0d", i), rdv, 64'(i));
      end

      // partial strobe on a zeroed word 1
      do_aw(BASE + 32'd8, 4'd0, 3'd3, 2'b01);
      do_w(64'd0, 8'hFF, 1'b1);
      do_b(resp);
      do_aw(BASE + 32'd8, 4'd0, 3'd3, 2'b01);
      do_w(64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 1'b1);
      do_b(resp);
      chk("strb_bresp", {62'd0, resp}, 64'd0);
      rd(1, rdv);
      chk("strb_mem1", rdv, 64'h0000_0000_CCCC_DDDD);

      // INCR running off the end of the store
      do_aw(BASE + 32'd8 * 32'd1022, 4'd3, 3'd3, 2'b01);
      for (int i = 0; i < 4; i++) do_w(64'hA0 + 64'(i), 8'hFF, i == 3);
      do_b(resp);
      chk("oor_bresp", {62'd0, resp}, 64'd2);
      chk("oor_beats", {32'd0, beat_count_o}, 64'(exp_beats));
      rd(1022, rdv); chk("oor_mem1022", rdv, 64'hA0);
      rd(1023, rdv); chk("oor_mem1023", rdv, 64'hA1);
      rd(0, rdv);    chk("oor_mem0",    rdv, 64'd0);

      // address below BASE
      do_aw(BASE - 32'd8, 4'd0, 3'd3, 2'b01);
      do_w(64'h55, 8'hFF, 1'b1);
      do_b(resp);
      chk("below_bresp", {62'd0, resp}, 64'd2);

      // awsize=2 burst discarded
      do_aw(BASE + 32'd16, 4'd1, 3'd2, 2'b01);
      do_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
      do_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
      do_b(resp);
      chk("size2_bresp", {62'd0, resp}, 64'd2);
      rd(2, rdv); chk("size2_mem2", rdv, 64'd2);
      rd(3, rdv); chk("size2_mem3", rdv, 64'd3);

      // WRAP burst discarded
      do_aw(BASE + 32'd32, 4'd1, 3'd3, 2'b10);
      do_w(64'hEEEE, 8'hFF, 1'b0);
      do_w(64'hEEEE, 8'hFF, 1'b1);
      do_b(resp);
      chk("wrap_bresp", {62'd0, resp}, 64'd2);
      rd(4, rdv); chk("wrap_mem4", rdv, 64'd4);
      rd(5, rdv); chk("wrap_mem5", rdv, 64'd5);

      // FIXED burst overwrites one word
      do_aw(BASE + 32'd8 * 32'd20, 4'd1, 3'd3, 2'b00);
      do_w(64'h11, 8'hFF, 1'b0);
      do_w(64'h22, 8'hFF, 1'b1);
      do_b(resp);
      chk("fixed_bresp", {62'd0, resp}, 64'd0);
      rd(20, rdv); chk("fixed_mem20", rdv, 64'h22);

      // early wlast, then bready held low
      do_aw(BASE + 32'd8 * 32'd30, 4'd3, 3'd3, 2'b01);
      do_w(64'h300, 8'hFF, 1'b0);
      do_w(64'h301, 8'hFF, 1'b1);
      chk("early_wready", {63'd0, s_axi_wready}, 64'd1);
      do_w(64'h302, 8'hFF, 1'b0);
      do_w(64'h303, 8'hFF, 1'b0);
      s_axi_awvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("hold_bvalid",  {63'd0, s_axi_bvalid},  64'd1);
         chk("hold_bresp",   {62'd0, s_axi_bresp},   64'd2);
         chk("hold_awready", {63'd0, s_axi_awready}, 64'd0);
         @(posedge aclk); @(negedge aclk);
      end
      s_axi_awvalid = 1'b0;
      chk("early_proto", {63'd0, proto_err_o}, 64'd1);
      do_b(resp);
      chk("early_bresp",  {62'd0, resp}, 64'd2);
      chk("early_beats",  {32'd0, beat_count_o},  64'(exp_beats));
      chk("early_bursts", {32'd0, burst_count_o}, 64'(exp_bursts));
      rd(33, rdv); chk("early_mem33", rdv, 64'h303);

      // reset after beat 2 of an 8-beat burst
      do_aw(BASE, 4'd7, 3'd3, 2'b01);
      do_w(64'h100, 8'hFF, 1'b0);
      do_w(64'h101, 8'hFF, 1'b0);
      rst_i = 1'b1;
      @(posedge aclk); @(negedge aclk);
      rst_i = 1'b0;
      exp_beats = 0; exp_bursts = 0;
      s_axi_bready = 1'b1;
      saw_bvalid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (s_axi_bvalid) saw_bvalid = 1'b1;
         @(posedge aclk); @(negedge aclk);
      end
      s_axi_bready = 1'b0;
      chk("mid_rst_no_b",   {63'd0, saw_bvalid},    64'd0);
      chk("mid_rst_beats",  {32'd0, beat_count_o},  64'd0);
      chk("mid_rst_bursts", {32'd0, burst_count_o}, 64'd0);
      chk("mid_rst_proto",  {63'd0, proto_err_o},   64'd0);
      chk("mid_rst_awready", {63'd0, s_axi_awready}, 64'd1);
      rd(0, rdv); chk("mid_rst_mem0", rdv, 64'h100);
      rd(1, rdv); chk("mid_rst_mem1", rdv, 64'h101);
      rd(2, rdv); chk("mid_rst_mem2", rdv, 64'd2);
      do_aw(BASE + 32'd8 * 32'd40, 4'd1, 3'd3, 2'b01);
      do_w(64'h400, 8'hFF, 1'b0);
      do_w(64'h401, 8'hFF, 1'b1);
      do_b(resp);
      chk("post_rst_bresp",  {62'd0, resp}, 64'd0);
      chk("post_rst_beats",  {32'd0, beat_count_o},  64'd2);
      chk("post_rst_bursts", {32'd0, burst_count_o}, 64'd1);
      rd(41, rdv); chk("post_rst_mem41", rdv, 64'h401);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
